// File: rtl/sap_cpu_core.sv
// SAP-style microsequenced CPU core: accumulator datapath over a multiplexed bus,
// flop-array RAM, host program-load port and a handshaked output register.
module sap_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              cf,
  output logic              zf,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } state_t;

  state_t state_r, next_state_s;

  logic [ADDR_W-1:0] pc_r, mar_r;
  logic [DATA_W-1:0] ir_r, a_r, b_r, out_data_r;
  logic              out_valid_r, halted_r, cf_r, zf_r;
  logic [DATA_W-1:0] ram_r [DEPTH];

  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] imm_s, mem_rd_s, alu_b_s;
  logic [DATA_W:0]   alu_sum_s;
  logic              alu_cin_s;

  logic mar_from_pc_s, ir_load_s, mar_from_ir_s, a_from_imm_s, pc_jump_s;
  logic out_load_s, a_from_mem_s, ram_store_s, b_load_s, alu_commit_s;

  assign opcode_s = ir_r[DATA_W-1:DATA_W-4];
  assign addr_s   = ir_r[ADDR_W-1:0];
  assign imm_s    = {4'b0000, ir_r[DATA_W-5:0]};
  assign mem_rd_s = ram_r[mar_r];

  // SUB is A + ~B + 1, so the carry out reads as "no borrow"
  assign alu_b_s   = (opcode_s == OP_SUB) ? ~b_r : b_r;
  assign alu_cin_s = (opcode_s == OP_SUB) ? 1'b1 : 1'b0;
  assign alu_sum_s = {1'b0, a_r} + {1'b0, alu_b_s} + {{DATA_W{1'b0}}, alu_cin_s};

  // Microsequencer: next state and per-state datapath strobes
  always_comb begin
    next_state_s  = state_r;
    mar_from_pc_s = 1'b0;
    ir_load_s     = 1'b0;
    mar_from_ir_s = 1'b0;
    a_from_imm_s  = 1'b0;
    pc_jump_s     = 1'b0;
    out_load_s    = 1'b0;
    a_from_mem_s  = 1'b0;
    ram_store_s   = 1'b0;
    b_load_s      = 1'b0;
    alu_commit_s  = 1'b0;
    case (state_r)
      T0: begin
        mar_from_pc_s = 1'b1;
        next_state_s  = T1;
      end
      T1: begin
        ir_load_s    = 1'b1;
        next_state_s = T2;
      end
      T2: begin
        next_state_s = T0;
        case (opcode_s)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_from_ir_s = 1'b1;
            next_state_s  = T3;
          end
          OP_LDI:  a_from_imm_s = 1'b1;
          OP_JMP:  pc_jump_s    = 1'b1;
          OP_JC:   pc_jump_s    = cf_r;
          OP_JZ:   pc_jump_s    = zf_r;
          OP_OUT:  out_load_s   = 1'b1;
          OP_HLT:  next_state_s = HALT;
          default: next_state_s = T0;
        endcase
      end
      T3: begin
        next_state_s = T0;
        case (opcode_s)
          OP_LDA:         a_from_mem_s = 1'b1;
          OP_STA:         ram_store_s  = 1'b1;
          OP_ADD, OP_SUB: begin
            b_load_s     = 1'b1;
            next_state_s = T4;
          end
          default:        next_state_s = T0;
        endcase
      end
      T4: begin
        alu_commit_s = 1'b1;
        next_state_s = T0;
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = T0;
    endcase
  end

  // State register; program mode parks the sequencer at T0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= T0;
    end else if (prog_en) begin
      state_r <= T0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= {ADDR_W{1'b0}};
      mar_r       <= {ADDR_W{1'b0}};
      ir_r        <= {DATA_W{1'b0}};
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
      cf_r        <= 1'b0;
      zf_r        <= 1'b0;
    end else if (prog_en) begin
      pc_r        <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      out_valid_r <= out_load_s;
      halted_r    <= (next_state_s == HALT);
      if (mar_from_pc_s) begin
        mar_r <= pc_r;
      end else if (mar_from_ir_s) begin
        mar_r <= addr_s;
      end
      if (ir_load_s) begin
        ir_r <= mem_rd_s;
        pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (pc_jump_s) begin
        pc_r <= addr_s;
      end
      if (a_from_imm_s) begin
        a_r <= imm_s;
      end else if (a_from_mem_s) begin
        a_r <= mem_rd_s;
      end else if (alu_commit_s) begin
        a_r <= alu_sum_s[DATA_W-1:0];
      end
      if (b_load_s) begin
        b_r <= mem_rd_s;
      end
      if (alu_commit_s) begin
        cf_r <= alu_sum_s[DATA_W];
        zf_r <= (alu_sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
      end
      if (out_load_s) begin
        out_data_r <= a_r;
      end
    end
  end

  // RAM: host writes in program mode, STA writes otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_r[i] <= {DATA_W{1'b0}};
      end
    end else if (prog_en) begin
      if (prog_we) begin
        ram_r[prog_addr] <= prog_data;
      end
    end else if (ram_store_s) begin
      ram_r[mar_r] <= a_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign halted    = halted_r;
  assign cf        = cf_r;
  assign zf        = zf_r;
  assign pc_dbg    = pc_r;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Self-checking bench for sap_cpu_core: directed programs plus random programs
// checked against an instruction-level model of the ISA.
module tb_sap_cpu_core;

  logic       clk = 1'b0;
  logic       rst, prog_en, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data, out_data;
  logic       out_valid, halted, cf, zf;
  logic [3:0] pc_dbg;

  logic        prog_en12, prog_we12;
  logic [7:0]  prog_addr12, pc_dbg12;
  logic [11:0] prog_data12, out_data12;
  logic        out_valid12, halted12, cf12, zf12;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] img [16];
  int m_ram [16];
  int m_a, m_cf, m_zf, m_pc, m_out, m_halt;

  always #5 clk = ~clk;

  sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data),
    .out_valid(out_valid), .halted(halted), .cf(cf), .zf(zf), .pc_dbg(pc_dbg)
  );

  sap_cpu_core #(.DATA_W(12), .ADDR_W(8)) dut12 (
    .clk(clk), .rst(rst), .prog_en(prog_en12), .prog_we(prog_we12),
    .prog_addr(prog_addr12), .prog_data(prog_data12), .out_data(out_data12),
    .out_valid(out_valid12), .halted(halted12), .cf(cf12), .zf(zf12), .pc_dbg(pc_dbg12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  // Reset, load img through the host port, release prog_en: caller is then in cycle 0
  task automatic load_img();
    rst = 1'b1; prog_en = 1'b0; prog_we = 1'b0;
    cyc();
    rst = 1'b0;
    prog_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
      cyc();
    end
    prog_we = 1'b0;
    prog_en = 1'b0;
    for (int i = 0; i < 16; i++) m_ram[i] = int'(img[i]);
    m_a = 0; m_cf = 0; m_zf = 0; m_pc = 0; m_out = 0; m_halt = 0;
  endtask

  // Execute one instruction of the ISA model; returns its cycle count
  task automatic exec_model(output int lat, output bit is_out);
    int ir, op, ad, s;
    ir = m_ram[m_pc];
    m_pc = (m_pc + 1) % 16;
    op = ir / 16;
    ad = ir % 16;
    lat = 3;
    is_out = 1'b0;
    case (op)
      1: begin m_a = m_ram[ad]; lat = 4; end
      2: begin s = m_a + m_ram[ad]; m_cf = int'(s > 255); m_a = s % 256; m_zf = int'(m_a == 0); lat = 5; end
      3: begin s = m_a + (255 - m_ram[ad]) + 1; m_cf = int'(s > 255); m_a = s % 256; m_zf = int'(m_a == 0); lat = 5; end
      4: begin m_ram[ad] = m_a; lat = 4; end
      5: m_a = ad;
      6: m_pc = ad;
      7: if (m_cf != 0) m_pc = ad;
      8: if (m_zf != 0) m_pc = ad;
      14: begin m_out = m_a; is_out = 1'b1; end
      15: m_halt = 1;
      default: lat = 3;
    endcase
  endtask

  // Run DUT alongside the model for up to max_instr instructions (or until HLT)
  task automatic run_model(input int max_instr);
    int lat;
    bit prev_out, now_out;
    prev_out = 1'b0;
    for (int n = 0; n < max_instr && m_halt == 0; n++) begin
      chk("pc", pc_dbg, m_pc);
      chk("cf", cf, m_cf);
      chk("zf", zf, m_zf);
      chk("out_data", out_data, m_out);
      chk("halted_run", halted, 0);
      exec_model(lat, now_out);
      for (int c = 0; c < lat; c++) begin
        chk("out_valid", out_valid, (c == 0) && prev_out);
        cyc();
      end
      prev_out = now_out;
    end
    if (m_halt != 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("halted_hold", halted, 1);
        chk("pc_frozen", pc_dbg, m_pc);
        chk("out_valid_halt", out_valid, (k == 0) && prev_out);
        chk("out_data_halt", out_data, m_out);
        cyc();
      end
    end
  endtask

  initial begin
    rst = 1'b1; prog_en = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    prog_en12 = 1'b0; prog_we12 = 1'b0; prog_addr12 = 8'h00; prog_data12 = 12'h000;
    @(negedge clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cf", cf, 0);
    chk("rst_zf", zf, 0);
    chk("rst_pc", pc_dbg, 0);

    // Reference program: 5 + 3 emitted in cycle 12, halt from cycle 15
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'h05; img[15] = 8'h03;
    load_img();
    for (int c = 0; c < 20; c++) begin
      chk("t1_out_valid", out_valid, c == 12);
      if (c == 12) chk("t1_out_data", out_data, 8'h08);
      chk("t1_halted", halted, c >= 15);
      cyc();
    end
    chk("t1_cf", cf, 0);
    chk("t1_zf", zf, 0);
    // prog_en exits HALT, keeps A/flags/out_data
    prog_en = 1'b1;
    cyc();
    chk("t1_prog_halted", halted, 0);
    chk("t1_prog_pc", pc_dbg, 0);
    chk("t1_prog_out", out_data, 8'h08);
    chk("t1_prog_ov", out_valid, 0);
    prog_en = 1'b0;
    m_a = 8; m_out = 8; m_cf = 0; m_zf = 0; m_pc = 0; m_halt = 0;
    run_model(10);
    chk("t1_rerun_out", out_data, 8'h08);

    // SUB with borrow
    clear_img();
    img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h05;
    load_img();
    run_model(10);
    chk("sub1_a", out_data, 8'hFE);
    chk("sub1_cf", cf, 0);
    chk("sub1_zf", zf, 0);

    // SUB equal operands
    img[0] = 8'h55;
    load_img();
    run_model(10);
    chk("sub2_a", out_data, 8'h00);
    chk("sub2_cf", cf, 1);
    chk("sub2_zf", zf, 1);

    // Carry branch: JC 8 taken, then JZ not taken
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h78;
    for (int i = 3; i < 8; i++) img[i] = 8'hF0;
    img[8] = 8'hE0; img[9] = 8'h2F; img[10] = 8'h83; img[11] = 8'hF0;
    img[14] = 8'hFF; img[15] = 8'h01;
    load_img();
    run_model(12);
    chk("br_pc", pc_dbg, 4'hC);
    chk("br_out", out_data, 8'h00);
    chk("br_cf", cf, 0);
    chk("br_zf", zf, 0);

    // STA then LDA round trip
    clear_img();
    img[0] = 8'h59; img[1] = 8'h4D; img[2] = 8'h50; img[3] = 8'h1D;
    img[4] = 8'hE0; img[5] = 8'hF0;
    load_img();
    run_model(10);
    chk("sta_out", out_data, 8'h09);
    chk("sta_pc", pc_dbg, 4'h6);

    // Asynchronous reset during ADD's T3 (cycle 9), then all-NOP RAM
    clear_img();
    img[0] = 8'h57; img[1] = 8'hE0; img[2] = 8'h2F;
    for (int i = 3; i < 15; i++) img[i] = 8'hF0;
    img[15] = 8'h03;
    load_img();
    for (int c = 0; c < 9; c++) cyc();
    chk("pre_rst_out", out_data, 8'h07);
    chk("pre_rst_pc", pc_dbg, 4'h3);
    rst = 1'b1;
    #1;
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_halted", halted, 0);
    chk("arst_cf", cf, 0);
    chk("arst_zf", zf, 0);
    chk("arst_pc", pc_dbg, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    m_a = 0; m_cf = 0; m_zf = 0; m_pc = 0; m_out = 0; m_halt = 0;
    run_model(17);
    chk("nop_pc_wrap", pc_dbg, 4'h1);
    chk("nop_halted", halted, 0);

    // Random programs against the ISA model
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
      load_img();
      run_model(30);
    end

    // Wide configuration: LDI truncation to operand field, long JMP, HALT exit
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    prog_en12 = 1'b1;
    prog_we12 = 1'b1; prog_addr12 = 8'h00; prog_data12 = 12'h5AB; cyc();
    prog_addr12 = 8'h01; prog_data12 = 12'h6C8; cyc();
    prog_addr12 = 8'hC8; prog_data12 = 12'hE00; cyc();
    prog_addr12 = 8'hC9; prog_data12 = 12'hF00; cyc();
    prog_we12 = 1'b0;
    prog_en12 = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 6) chk("w_jmp_pc", pc_dbg12, 8'hC8);
      chk("w_out_valid", out_valid12, c == 9);
      if (c == 9) chk("w_ldi", out_data12, 12'h0AB);
      chk("w_halted", halted12, c >= 12);
      cyc();
    end
    chk("w_halt_pc", pc_dbg12, 8'hCA);
    prog_en12 = 1'b1;
    cyc();
    chk("w_prog_halted", halted12, 0);
    chk("w_prog_pc", pc_dbg12, 8'h00);
    chk("w_prog_out", out_data12, 12'h0AB);
    prog_en12 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
